// File: rtl/door_sequencer_if.sv
// Signal bundle between the car-door sequencer and its controller: timebase and
// request inputs to the sequencer, motor commands and door status back.
interface door_sequencer_if;
    logic       tick;
    logic       open_req;
    logic       close_btn;
    logic       obstruct;
    logic       car_moving;
    logic       door_open_drv;
    logic       door_close_drv;
    logic       door_closed;
    logic [1:0] state;

    modport master (
        output tick, open_req, close_btn, obstruct, car_moving,
        input  door_open_drv, door_close_drv, door_closed, state
    );

    modport slave (
        input  tick, open_req, close_btn, obstruct, car_moving,
        output door_open_drv, door_close_drv, door_closed, state
    );
endinterface

// File: rtl/door_sequencer.sv
// Elevator car-door sequencer: Moore FSM paced by a one-cycle tick strobe, with
// obstruction/call reopen, close-button shortcut and a car-moving open interlock.
module door_sequencer #(
    parameter int OPEN_TICKS  = 3,
    parameter int HOLD_TICKS  = 5,
    parameter int CLOSE_TICKS = 3,
    parameter int TW          = 4
) (
    input  logic            clk,
    input  logic            rst,
    door_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        CLOSED  = 2'b00,
        OPENING = 2'b01,
        HOLD    = 2'b10,
        CLOSING = 2'b11
    } state_t;

    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_TICKS - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_TICKS - 1);
    localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_TICKS - 1);

    state_t        state;
    logic [TW-1:0] cnt;

    // cnt holds the number of ticks already seen in the current state; the last
    // tick of a timed state moves on instead of incrementing, so cnt never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLOSED;
            cnt   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch
            // below sees the pre-edge values of state and cnt.
            unique case (state)
                CLOSED: begin
                    cnt <= '0;
                    if (bus.open_req && !bus.car_moving)
                        state <= OPENING;
                end
                OPENING: begin
                    if (bus.tick) begin
                        if (cnt == OPEN_LAST) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.obstruct || bus.open_req) begin
                        cnt <= '0;
                    end else if (bus.close_btn) begin
                        state <= CLOSING;
                        cnt   <= '0;
                    end else if (bus.tick) begin
                        if (cnt == HOLD_LAST) begin
                            state <= CLOSING;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CLOSING: begin
                    // A tick coinciding with a reopen is dropped; the reopen is a full travel.
                    if (bus.obstruct || bus.open_req) begin
                        state <= OPENING;
                        cnt   <= '0;
                    end else if (bus.tick) begin
                        if (cnt == CLOSE_LAST) begin
                            state <= CLOSED;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= CLOSED;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Pure decode of the state register: no input reaches an output combinationally.
    assign bus.state          = state;
    assign bus.door_open_drv  = (state == OPENING);
    assign bus.door_close_drv = (state == CLOSING);
    assign bus.door_closed    = (state == CLOSED);

endmodule

// File: tb/tb_door_sequencer.sv
// Directed bench for door_sequencer: stimulus queues hand-computed expected
// states, a negedge monitor pops and compares them against the DUT outputs.
module tb_door_sequencer;

    localparam logic [1:0] S_CLOSED  = 2'b00;
    localparam logic [1:0] S_OPENING = 2'b01;
    localparam logic [1:0] S_HOLD    = 2'b10;
    localparam logic [1:0] S_CLOSING = 2'b11;

    typedef struct {
        logic [1:0] st;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    door_sequencer_if bus ();

    door_sequencer #(
        .OPEN_TICKS (3),
        .HOLD_TICKS (5),
        .CLOSE_TICKS(3),
        .TW         (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    string phase    = "init";

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got {state,open,close,closed}=%b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are stable at the negedge following the deciding posedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [4:0] req;
            e   = exp_q.pop_front();
            req = {e.st, e.st == S_OPENING, e.st == S_CLOSING, e.st == S_CLOSED};
            check(e.name, {bus.state, bus.door_open_drv, bus.door_close_drv, bus.door_closed}, req);
        end
    end

    // Apply one clock of inputs; exp is the state expected after that edge.
    task automatic step(input logic t, input logic o, input logic c, input logic ob,
                        input logic cm, input logic r, input logic [1:0] exp);
        exp_t e;
        bus.tick       = t;
        bus.open_req   = o;
        bus.close_btn  = c;
        bus.obstruct   = ob;
        bus.car_moving = cm;
        rst            = r;
        @(posedge clk);
        e.st   = exp;
        e.name = phase;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input logic [1:0] exp);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp);
    endtask

    // n ticks spaced 4 clocks; the last tick is expected to land in fin.
    task automatic ticks(input int n, input logic [1:0] during, input logic [1:0] fin);
        for (int i = 0; i < n; i++) begin
            logic [1:0] after;
            after = (i == n - 1) ? fin : during;
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, after);
            for (int k = 0; k < 3; k++) idle(after);
        end
    endtask

    task automatic open_now();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, S_OPENING);
    endtask

    initial begin
        bus.tick = 1'b0; bus.open_req = 1'b0; bus.close_btn = 1'b0;
        bus.obstruct = 1'b0; bus.car_moving = 1'b0;

        phase = "reset";
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CLOSED);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CLOSED);
        idle(S_CLOSED);

        phase = "full_cycle";
        open_now();
        ticks(3, S_OPENING, S_HOLD);
        ticks(5, S_HOLD, S_CLOSING);
        ticks(3, S_CLOSING, S_CLOSED);
        idle(S_CLOSED);

        phase = "hold_restart";
        open_now();
        ticks(3, S_OPENING, S_HOLD);
        ticks(4, S_HOLD, S_HOLD);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S_HOLD);
        ticks(5, S_HOLD, S_CLOSING);
        ticks(3, S_CLOSING, S_CLOSED);

        phase = "reopen";
        open_now();
        ticks(3, S_OPENING, S_HOLD);
        ticks(5, S_HOLD, S_CLOSING);
        ticks(2, S_CLOSING, S_CLOSING);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S_OPENING);
        ticks(3, S_OPENING, S_HOLD);
        phase = "close_btn";
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_CLOSING);
        ticks(3, S_CLOSING, S_CLOSED);

        phase = "interlock";
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, S_CLOSED);
        idle(S_CLOSED);
        ticks(2, S_CLOSED, S_CLOSED);
        phase = "hold_prio";
        open_now();
        ticks(3, S_OPENING, S_HOLD);
        ticks(3, S_HOLD, S_HOLD);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, S_HOLD);
        ticks(5, S_HOLD, S_CLOSING);
        phase = "closing_tick_obstruct";
        ticks(2, S_CLOSING, S_CLOSING);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S_OPENING);
        ticks(3, S_OPENING, S_HOLD);
        phase = "closing_open_req";
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_CLOSING);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, S_OPENING);

        phase = "back_to_back_ticks";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_OPENING);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_OPENING);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_HOLD);
        phase = "car_moving_in_hold";
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_HOLD);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_CLOSING);
        ticks(3, S_CLOSING, S_CLOSED);

        phase = "midop_reset";
        open_now();
        ticks(2, S_OPENING, S_OPENING);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CLOSED);
        idle(S_CLOSED);
        open_now();
        ticks(3, S_OPENING, S_HOLD);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_CLOSING);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CLOSED);
        idle(S_CLOSED);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
